mesh_mvm_engine: RTL and testbench
==================================

# mesh_mvm_engine

Parametrised matrix-vector engine: ROWS×COLS weight-stationary store with ROWS parallel MAC lanes walking one column per cycle. It adds valid/ready handshakes on vector input and result output, signed/unsigned arithmetic, accumulate-into-previous-result mode, a configurable accumulator width and a preload error flag. It replaces the fixed-start mesh top and sits between the weight loader and the result consumer in the accelerator datapath.

## Interface
- DW, 8, weight and x element width
- ROWS, 5, weight rows / output lanes
- COLS, 5, weight columns / x elements
- ROW_W, 3, row address width
- COL_W, 3, column address width
- CYCLE_W, 5, column counter width
- AW, 19, accumulator/result width per lane (≥ 2*DW)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- preload_valid  in  1  weight write request
- preload_addr  in  ROW_W+COL_W  {row, col}
- preload_data  in  DW  weight value
- preload_err  out  1  one-cycle pulse: preload rejected
- in_valid  in  1  x vector offered
- in_ready  out  1  engine can accept x vector
- x_vector_flat  in  COLS*DW  x[c] at bits [(c+1)*DW-1 -: DW]
- signed_mode  in  1  sampled on accept; 1 = two's complement operands
- acc_mode  in  1  sampled on accept; 1 = accumulate onto held result
- out_valid  out  1  result_flat valid
- out_ready  in  1  consumer accepts result
- result_flat  out  ROWS*AW  lane r at bits [(r+1)*AW-1 -: AW]
- busy  out  1  state ≠ S_IDLE
- state  out  2  FSM state code

## Operation
- States: S_IDLE=0, S_LOAD_X=1, S_MAC=2, S_STORE=3.
- S_IDLE: in_ready=1. in_valid&in_ready at an edge latches x_vector_flat, signed_mode, acc_mode → S_LOAD_X.
- S_LOAD_X (1 cycle): acc[r] ← 0 (acc_mode=0) or result lane r (acc_mode=1); cycle ← 0 → S_MAC.
- S_MAC: each cycle acc[r] ← acc[r] + ext(w[r][cycle]) * ext(x[cycle]) for all r; cycle+1. On cycle==COLS-1: result_flat ← final acc, out_valid ← 1 → S_STORE.
- S_STORE: out_valid held, result_flat stable. out_valid&out_ready at edge → out_valid ← 0, → S_IDLE. in_ready=0; in_valid ignored.
- ext(): sign-extend when latched signed_mode=1, else zero-extend; product 2*DW bits extended to AW; sums wrap modulo 2^AW, no saturation.
- Preload: accepted only in S_IDLE with row<ROWS and col<COLS; w[row][col] ← preload_data at the edge. Otherwise weight unchanged and preload_err=1 for the following cycle.
- Preload and input accept at the same S_IDLE edge: both take effect; the computation uses the new weight.
- result_flat holds its last value through S_IDLE until the next S_MAC completion.

## Timing
- Reset (async, immediate): state=S_IDLE, all weights 0, result_flat 0, out_valid 0, preload_err 0, busy 0, cycle 0; in_ready=1 (combinational from state).
- Reset mid-operation aborts the computation; outputs return to reset values at once; no partial result is emitted.
- Latency: accept at edge E0 → out_valid high after edge E0+COLS+1 (6 cycles at COLS=5).
- Throughput: one vector per COLS+2 cycles plus output stall cycles.
- in_ready, busy and state are combinational from the state register; preload_err, out_valid and result_flat are registered.

## Test plan
- Weights w[r][c]=r+c+1, x={5,4,3,2,1} (x[0]=1), unsigned, out_ready=1 → out_valid 6 cycles after accept; lanes 55,70,85,100,115.
- Same weights and x, acc_mode=1 on a second vector → 110,140,170,200,230.
- All weights 8'h02, all x 8'hFF: signed_mode=1 → each lane 19'h7FFF6 (−10); signed_mode=0 → each lane 2550.
- out_ready low 10 cycles in S_STORE → out_valid stays 1, result_flat stable, in_ready 0, in_valid ignored. out_ready=1 → S_IDLE next cycle.
- Preload during S_MAC, and preload with col=5 in S_IDLE → preload_err pulses one cycle each; weights unchanged, result unaffected.
- rst_n low during S_MAC cycle 2 → immediate S_IDLE, out_valid 0, result_flat 0, weights 0; a new vector after reload gives the correct result.

Source files
------------

// File: rtl/mesh_mvm_engine_if.sv
// Handshake and bus bundle between the weight loader, the vector producer,
// the result consumer and mesh_mvm_engine.
interface mesh_mvm_engine_if #(
  parameter int DW    = 8,
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int ROW_W = 3,
  parameter int COL_W = 3,
  parameter int AW    = 19
);
  logic                     preload_valid;
  logic [ROW_W+COL_W-1:0]   preload_addr;
  logic [DW-1:0]            preload_data;
  logic                     preload_err;

  logic                     in_valid;
  logic                     in_ready;
  logic [COLS*DW-1:0]       x_vector_flat;
  logic                     signed_mode;
  logic                     acc_mode;

  logic                     out_valid;
  logic                     out_ready;
  logic [ROWS*AW-1:0]       result_flat;

  modport master (
    output preload_valid, preload_addr, preload_data,
    output in_valid, x_vector_flat, signed_mode, acc_mode,
    output out_ready,
    input  preload_err, in_ready, out_valid, result_flat
  );

  modport slave (
    input  preload_valid, preload_addr, preload_data,
    input  in_valid, x_vector_flat, signed_mode, acc_mode,
    input  out_ready,
    output preload_err, in_ready, out_valid, result_flat
  );
endinterface

// File: rtl/mesh_mvm_engine.sv
// Weight-stationary matrix-vector engine: ROWS MAC lanes walk one weight column
// per cycle, with valid/ready on the x vector and on the result.
module mesh_mvm_engine #(
  parameter int DW      = 8,
  parameter int ROWS    = 5,
  parameter int COLS    = 5,
  parameter int ROW_W   = 3,
  parameter int COL_W   = 3,
  parameter int CYCLE_W = 5,
  parameter int AW      = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  mesh_mvm_engine_if.slave    bus,
  output logic                busy,
  output logic [1:0]          state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_X = 2'd1;
  localparam logic [1:0] S_MAC    = 2'd2;
  localparam logic [1:0] S_STORE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CYCLE_W-1:0]  cycle_q, cycle_d;
  logic [COLS*DW-1:0]  x_q, x_d;
  logic                signed_q, signed_d;
  logic                acc_mode_q, acc_mode_d;
  logic [AW-1:0]       acc_q [ROWS];
  logic [AW-1:0]       acc_d [ROWS];
  logic [DW-1:0]       w_q [ROWS][COLS];
  logic [DW-1:0]       w_d [ROWS][COLS];
  logic [ROWS*AW-1:0]  result_q, result_d;
  logic                out_valid_q, out_valid_d;
  logic                preload_err_q, preload_err_d;

  logic [ROW_W-1:0]    pre_row;
  logic [COL_W-1:0]    pre_col;
  logic                pre_ok;
  logic                accept;
  logic                last_col;
  logic [COL_W-1:0]    col_idx;
  logic [DW-1:0]       x_arr [COLS];
  logic [DW-1:0]       x_cur;
  logic [2*DW-1:0]     x_ext;
  logic [2*DW-1:0]     w_ext [ROWS];
  logic [2*DW-1:0]     prod2 [ROWS];
  logic [AW-1:0]       prod [ROWS];

  assign pre_row  = bus.preload_addr[ROW_W+COL_W-1:COL_W];
  assign pre_col  = bus.preload_addr[COL_W-1:0];
  assign pre_ok   = bus.preload_valid && (state_q == S_IDLE) &&
                    ({1'b0, pre_row} < (ROW_W+1)'(ROWS)) &&
                    ({1'b0, pre_col} < (COL_W+1)'(COLS));
  assign accept   = bus.in_valid && (state_q == S_IDLE);
  assign last_col = (cycle_q == CYCLE_W'(COLS-1));
  assign col_idx  = cycle_q[COL_W-1:0];

  // Operands are extended to 2*DW first so one multiplier serves both modes;
  // the low 2*DW bits of the product are exact for signed and unsigned alike.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      x_arr[c] = x_q[c*DW +: DW];
    end
    x_cur = x_arr[col_idx];
    x_ext = signed_q ? {{DW{x_cur[DW-1]}}, x_cur} : {{DW{1'b0}}, x_cur};
    for (int r = 0; r < ROWS; r++) begin
      w_ext[r] = signed_q ? {{DW{w_q[r][col_idx][DW-1]}}, w_q[r][col_idx]}
                          : {{DW{1'b0}}, w_q[r][col_idx]};
      prod2[r] = w_ext[r] * x_ext;
      prod[r]  = signed_q ? {{(AW-2*DW){prod2[r][2*DW-1]}}, prod2[r]}
                          : {{(AW-2*DW){1'b0}}, prod2[r]};
    end
  end

  always_comb begin
    state_d       = state_q;
    cycle_d       = cycle_q;
    x_d           = x_q;
    signed_d      = signed_q;
    acc_mode_d    = acc_mode_q;
    acc_d         = acc_q;
    w_d           = w_q;
    result_d      = result_q;
    out_valid_d   = out_valid_q;
    preload_err_d = bus.preload_valid && !pre_ok;

    if (pre_ok) begin
      w_d[pre_row][pre_col] = bus.preload_data;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d        = bus.x_vector_flat;
          signed_d   = bus.signed_mode;
          acc_mode_d = bus.acc_mode;
          state_d    = S_LOAD_X;
        end
      end
      S_LOAD_X: begin
        for (int r = 0; r < ROWS; r++) begin
          acc_d[r] = acc_mode_q ? result_q[r*AW +: AW] : '0;
        end
        cycle_d = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        for (int r = 0; r < ROWS; r++) begin
          acc_d[r] = acc_q[r] + prod[r];
        end
        cycle_d = cycle_q + CYCLE_W'(1);
        if (last_col) begin
          for (int r = 0; r < ROWS; r++) begin
            result_d[r*AW +: AW] = acc_q[r] + prod[r];
          end
          out_valid_d = 1'b1;
          cycle_d     = '0;
          state_d     = S_STORE;
        end
      end
      S_STORE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset clears the weight store too, so an aborted run leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cycle_q       <= '0;
      x_q           <= '0;
      signed_q      <= 1'b0;
      acc_mode_q    <= 1'b0;
      result_q      <= '0;
      out_valid_q   <= 1'b0;
      preload_err_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        acc_q[r] <= '0;
        for (int c = 0; c < COLS; c++) begin
          w_q[r][c] <= '0;
        end
      end
    end else begin
      state_q       <= state_d;
      cycle_q       <= cycle_d;
      x_q           <= x_d;
      signed_q      <= signed_d;
      acc_mode_q    <= acc_mode_d;
      result_q      <= result_d;
      out_valid_q   <= out_valid_d;
      preload_err_q <= preload_err_d;
      acc_q         <= acc_d;
      w_q           <= w_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.result_flat = result_q;
  assign bus.preload_err = preload_err_q;
  assign busy            = (state_q != S_IDLE);
  assign state           = state_q;

endmodule

// File: tb/tb_mesh_mvm_engine.sv
// Randomised and directed bench for mesh_mvm_engine against a plain
// arithmetic matrix-vector reference model.
module tb_mesh_mvm_engine;
  localparam int DW = 8, ROWS = 5, COLS = 5, ROW_W = 3, COL_W = 3, CYCLE_W = 5, AW = 19;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] state;

  int err_count   = 0;
  int check_count = 0;

  logic [DW-1:0] w_m   [ROWS][COLS];
  logic [AW-1:0] res_m [ROWS];
  logic [DW-1:0] x_m   [COLS];

  mesh_mvm_engine_if #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W),
                       .COL_W(COL_W), .AW(AW)) bus ();

  mesh_mvm_engine #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W),
                    .COL_W(COL_W), .CYCLE_W(CYCLE_W), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // y[r] = (acc ? previous y[r] : 0) + sum_c w[r][c]*x[c], modulo 2^AW.
  function automatic logic [AW-1:0] ref_lane(input int r, input bit sgn, input bit acc);
    longint s, a, b;
    s = acc ? longint'(res_m[r]) : 64'sd0;
    for (int c = 0; c < COLS; c++) begin
      a = sgn ? longint'($signed(w_m[r][c])) : longint'(w_m[r][c]);
      b = sgn ? longint'($signed(x_m[c]))    : longint'(x_m[c]);
      s += a * b;
    end
    return AW'(s);
  endfunction

  function automatic logic [AW-1:0] lane(input int r);
    return bus.result_flat[r*AW +: AW];
  endfunction

  task automatic load_weight(input int row, input int col, input logic [DW-1:0] data);
    bit bad;
    bad = (row >= ROWS) || (col >= COLS);
    @(negedge clk);
    bus.preload_valid = 1'b1;
    bus.preload_addr  = {ROW_W'(row), COL_W'(col)};
    bus.preload_data  = data;
    @(posedge clk); #1;
    bus.preload_valid = 1'b0;
    checkOutput($sformatf("preload_err w[%0d][%0d]", row, col), 64'(bus.preload_err), 64'(bad));
    if (!bad) w_m[row][col] = data;
  endtask

  task automatic load_all(input int mode);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        load_weight(r, c, (mode == 0) ? DW'(r + c + 1) :
                          (mode == 1) ? DW'(2) : DW'($urandom));
  endtask

  task automatic applyStimulus(input bit sgn, input bit acc, input int stall,
                               input bit inject_pre, input string tag);
    logic [AW-1:0]      exp_l [ROWS];
    logic [ROWS*AW-1:0] held;
    int lat;
    bit seen;
    for (int r = 0; r < ROWS; r++) exp_l[r] = ref_lane(r, sgn, acc);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.signed_mode = sgn;
    bus.acc_mode    = acc;
    bus.out_ready   = 1'b0;
    for (int c = 0; c < COLS; c++) bus.x_vector_flat[c*DW +: DW] = x_m[c];
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput({tag, " accept state"}, 64'(state), 64'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (inject_pre && lat == 2) begin
        bus.preload_valid = 1'b1;
        bus.preload_addr  = '0;
        bus.preload_data  = 8'h77;
      end
      @(posedge clk); #1;
      lat++;
      if (inject_pre && lat == 3) begin
        bus.preload_valid = 1'b0;
        checkOutput({tag, " mac preload_err"}, 64'(bus.preload_err), 64'd1);
      end
      if (inject_pre && lat == 4)
        checkOutput({tag, " mac preload_err clear"}, 64'(bus.preload_err), 64'd0);
      seen = bus.out_valid;
    end
    checkOutput({tag, " out_valid seen"}, 64'(seen), 64'd1);
    checkOutput({tag, " latency"}, 64'(lat), 64'(COLS + 1));
    for (int r = 0; r < ROWS; r++)
      checkOutput($sformatf("%s lane%0d", tag, r), 64'(lane(r)), 64'(exp_l[r]));
    held = bus.result_flat;
    for (int k = 0; k < stall; k++) begin
      bus.in_valid      = 1'b1;
      bus.x_vector_flat = {ROWS{AW'($urandom)}};
      @(posedge clk); #1;
      checkOutput({tag, " stall out_valid"}, 64'(bus.out_valid), 64'd1);
      checkOutput({tag, " stall stable"}, 64'(bus.result_flat === held), 64'd1);
      checkOutput({tag, " stall in_ready"}, 64'(bus.in_ready), 64'd0);
      checkOutput({tag, " stall state"}, 64'(state), 64'd3);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, " back to idle"}, 64'(state), 64'd0);
    checkOutput({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, " idle hold"}, 64'(bus.result_flat === held), 64'd1);
    for (int r = 0; r < ROWS; r++) res_m[r] = exp_l[r];
  endtask

  initial begin
    int want [ROWS];
    rst_n             = 1'b0;
    bus.preload_valid = 1'b0;
    bus.preload_addr  = '0;
    bus.preload_data  = '0;
    bus.in_valid      = 1'b0;
    bus.x_vector_flat = '0;
    bus.signed_mode   = 1'b0;
    bus.acc_mode      = 1'b0;
    bus.out_ready     = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      res_m[r] = '0;
      for (int c = 0; c < COLS; c++) w_m[r][c] = '0;
    end
    #12;
    checkOutput("reset state", 64'(state), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset preload_err", 64'(bus.preload_err), 64'd0);
    checkOutput("reset result", 64'(bus.result_flat == '0), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    load_all(0);
    for (int c = 0; c < COLS; c++) x_m[c] = DW'(c + 1);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, "directed");
    want = '{55, 70, 85, 100, 115};
    for (int r = 0; r < ROWS; r++)
      checkOutput($sformatf("directed const lane%0d", r), 64'(lane(r)), 64'(want[r]));
    applyStimulus(1'b0, 1'b1, 0, 1'b0, "accum");
    want = '{110, 140, 170, 200, 230};
    for (int r = 0; r < ROWS; r++)
      checkOutput($sformatf("accum const lane%0d", r), 64'(lane(r)), 64'(want[r]));

    load_all(1);
    for (int c = 0; c < COLS; c++) x_m[c] = 8'hFF;
    applyStimulus(1'b1, 1'b0, 0, 1'b0, "signed");
    for (int r = 0; r < ROWS; r++)
      checkOutput($sformatf("signed const lane%0d", r), 64'(lane(r)), 64'h7FFF6);
    applyStimulus(1'b0, 1'b0, 10, 1'b0, "unsigned stall");
    for (int r = 0; r < ROWS; r++)
      checkOutput($sformatf("unsigned const lane%0d", r), 64'(lane(r)), 64'd2550);

    load_weight(1, 5, 8'h33);
    load_weight(5, 0, 8'h44);
    @(posedge clk); #1;
    checkOutput("preload_err one cycle", 64'(bus.preload_err), 64'd0);
    load_all(0);
    for (int c = 0; c < COLS; c++) x_m[c] = DW'(c + 1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, "mac preload");

    for (int it = 0; it < 6; it++) begin
      load_all(2);
      for (int c = 0; c < COLS; c++) x_m[c] = DW'($urandom);
      applyStimulus(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0,
                    $sformatf("rand%0d", it));
    end

    // Abort in the middle of the MAC walk and check nothing survives.
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort state", 64'(state), 64'd0);
    checkOutput("abort out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("abort result", 64'(bus.result_flat == '0), 64'd1);
    checkOutput("abort in_ready", 64'(bus.in_ready), 64'd1);
    for (int r = 0; r < ROWS; r++) begin
      res_m[r] = '0;
      for (int c = 0; c < COLS; c++) w_m[r][c] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < COLS; c++) x_m[c] = DW'($urandom_range(1, 255));
    applyStimulus(1'b0, 1'b1, 0, 1'b0, "zero weights");
    load_all(2);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, "after reload");

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
